// File: rtl/scrambler_frame_ctrl_if.sv
// Byte-stream bundle for the frame scrambler.
// The input side carries in_data, in_valid and in_ready. The output side
// carries out_data, out_valid, out_ready and out_last.
//   slave  : the scrambler. It consumes the input stream and produces the
//            output stream.
//   master : the environment. It is the byte source feeding the scrambler
//            and the line encoder draining it.
interface scrambler_frame_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/scrambler_frame_ctrl.sv
// Frame controller and datapath for the additive scrambler x^15+x^14+1.
// It handles one frame at a time. For each frame it loads the seed, steps the
// 15-bit LFSR eight times per accepted byte, and counts bytes up to the
// programmed length. Because the scrambler is additive, the same path also
// descrambles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      frame start pulse, sampled only in IDLE
//   seed       LFSR seed, captured on an accepted start (0 maps to SEED_ZERO_SUB)
//   frame_len  frame length minus one, captured on an accepted start
//   bypass     captured on start; data passes unmodified but the LFSR still steps
//   abort      synchronous frame abort, effective in any non-IDLE state
//   bus        byte streams (slave side): in_* input, out_* registered output
//   busy       high in any state other than IDLE
//   done       one-cycle pulse after the last byte leaves the output register
//   lfsr_state current LFSR contents
module scrambler_frame_ctrl #(
  parameter int unsigned LEN_W         = 8,
  parameter logic [14:0] SEED_ZERO_SUB = 15'h7FFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [14:0]          seed,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 bypass,
  input  logic                 abort,
  scrambler_frame_ctrl_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [14:0]          lfsr_state
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t           state_q,     state_d;
  logic [14:0]      seed_q,      seed_d;
  logic             bypass_q,    bypass_d;
  logic [LEN_W-1:0] counter_q,   counter_d;
  logic [14:0]      lfsr_q,      lfsr_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             done_q,      done_d;

  logic             in_ready_c;
  logic             accept;
  logic             out_xfer;
  logic [7:0]       mask;
  logic [14:0]      lfsr_next;

  // Eight serial LFSR steps unrolled into one cycle. Feedback bit n is the
  // mask for data bit n, so bit 0 of each byte is scrambled first.
  always_comb begin
    lfsr_next = lfsr_q;
    mask      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mask[i]   = lfsr_next[14] ^ lfsr_next[13];
      lfsr_next = {lfsr_next[13:0], mask[i]};
    end
  end

  // in_ready is gated by abort. An abort therefore never coincides with a
  // completed input handshake, and the source keeps the byte it offered.
  assign in_ready_c = (state_q == ST_RUN) && !abort &&
                      (!out_valid_q || bus.out_ready);
  assign accept     = in_ready_c && bus.in_valid;
  assign out_xfer   = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    bypass_d    = bypass_q;
    counter_d   = counter_q;
    lfsr_d      = lfsr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d    = (seed == '0) ? SEED_ZERO_SUB : seed;
          bypass_d  = bypass;
          counter_d = frame_len;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        lfsr_d  = seed_q;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        // A new accept overrides the drain above, so the register reloads
        // and out_valid stays high.
        if (accept) begin
          out_data_d  = bypass_q ? bus.in_data : (bus.in_data ^ mask);
          out_valid_d = 1'b1;
          out_last_d  = (counter_q == '0);
          lfsr_d      = lfsr_next;
          if (counter_q == '0) begin
            state_d = ST_DRAIN;
          end else begin
            counter_d = counter_q - LEN_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (out_xfer && out_last_q) begin
          done_d      = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // abort wins over everything in a frame. The byte in the output register
    // is dropped, and the LFSR keeps its value (this also applies in LOAD).
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
      lfsr_d      = lfsr_q;
      counter_d   = counter_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      bypass_q    <= 1'b0;
      counter_q   <= '0;
      lfsr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      bypass_q    <= bypass_d;
      counter_q   <= counter_d;
      lfsr_q      <= lfsr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign lfsr_state    = lfsr_q;

endmodule
